uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single 8N1 UART transmit serializer, clocked at the bit rate, between NREQ requesters.
- Each requester posts a fixed-length message of MSG_BYTES bytes.
- The block arbitrates round-robin and latches the winner's message. It feeds the bytes to the serializer through its start/data interface, paced by bit-period counting, because the serializer provides no busy flag.
- Sits between the command/response decode logic and the serializer.

Parameters:
- NREQ, 4, number of requesters.
- MSG_BYTES, 2, bytes per message; byte 0 is sent first; messages are never interleaved.
- FRAME_CYCLES, 11, clocks from the cycle in which the serializer samples tx_start until it is idle again. Must be >= 11.
- GAP_CYCLES, 1, extra idle-line clocks between consecutive frames. Must be >= 0.

Ports:
- clk_115200hz  in  1  bit-rate clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; level, held until ack.
- req_msg  in  NREQ*MSG_BYTES*8  requester i occupies slice [i*MSG_BYTES*8 +: MSG_BYTES*8]. Byte j of that slice is bits [j*8 +: 8].
- ack  out  NREQ  one-cycle pulse to the granted requester; its message is latched.
- grant_id  out  $clog2(NREQ)  index of the requester currently or last served.
- busy  out  1  high in every state except IDLE.
- tx_start  out  1  one-cycle start strobe to the serializer.
- tx_data  out  8  byte to the serializer; bit 0 goes on the line first.

Behaviour:
- Serializer contract, which this block guarantees:
  - tx_start is high for exactly one clock, and only when the serializer is idle.
  - tx_data is stable from the tx_start cycle until at least FRAME_CYCLES-2 clocks after it.
- States: HOLD, IDLE, SEND, WAIT.
- Reset values:
  - state=HOLD, ack=0, tx_start=0, tx_data=8'hFF, grant_id=NREQ-1, busy=1.
  - RR pointer=NREQ-1, so req[0] has the highest priority first.
  - Byte index=0; delay counter=FRAME_CYCLES+GAP_CYCLES-1.
- HOLD: counts down to 0 and then goes to IDLE. This lets a frame already in flight at reset finish before the next tx_start.
- IDLE: if req != 0 at a clock edge:
  - Select the winner w: the first asserted bit searching upward from pointer+1, with wrap-around.
  - Latch req_msg slice w into the message register, set grant_id=w and pointer=w.
  - Byte index=0; go to SEND.
  - If req == 0, stay in IDLE.
- SEND (exactly one cycle):
  - tx_start=1; tx_data=latched byte[index].
  - ack[w]=1 only in the SEND for index 0.
  - Load counter=FRAME_CYCLES+GAP_CYCLES-1; go to WAIT.
- WAIT:
  - tx_start=0; tx_data held; counter decrements.
  - At counter==0: if index<MSG_BYTES-1, increment index and go to SEND; otherwise go to IDLE.
- Timing:
  - tx_start pulses within a message are spaced exactly FRAME_CYCLES+GAP_CYCLES clocks apart (12 by default).
  - Latency from req sampled in IDLE to tx_start is 1 clock.
  - Spacing from the last tx_start of one message to the first tx_start of the next is FRAME_CYCLES+GAP_CYCLES+1 clocks (includes the IDLE cycle).
- Boundaries:
  - A req dropped after its grant: the message is still sent in full.
  - A req changed or held after ack: treated as a new message, but only at the next IDLE, subject to RR.
  - Multiple simultaneous reqs: RR order. One continuously-asserted requester cannot starve the others.
  - A req whose bits arrive during SEND/WAIT is ignored until IDLE; there is no queueing beyond the level req.
  - reset mid-message: immediate return to HOLD. The rest of the message is dropped with no further ack; the requester has already been acked.
  - Single requester, NREQ=1: grant_id is 1 bit wide, tied 0.

Decomposition:
- Package uart_tx_pkg:
  - State encoding (HOLD/IDLE/SEND/WAIT).
  - FRAME_CYCLES_MIN=11.
  - Idle line byte 8'hFF.
  - Counter width function.
- Sub-module rr_arbiter (NREQ):
  - Combinational rotate-priority winner and a valid flag, from req and pointer.
  - The pointer register stays in uart_tx_scheduler.

Test Plan:
- Post-reset holdoff: reset released with req=4'b0001 held → no tx_start for 12 clocks. Then ack[0] and tx_start together, tx_data=byte0; a second tx_start 12 clocks later with byte1.
- Simultaneous requests: req=4'b1011 held constantly → grant order 0,1,3,0,… Each message is two tx_starts 12 clocks apart, and messages are 13 clocks apart.
- Data integrity: requester 2 msg=16'hA53C → tx_data=8'h3C then 8'hA5. tx_data is constant across each full 12-clock window. A bench model of the serializer decodes the line to 3C, A5.
- Drop after ack: req[1] pulsed for one cycle only → full two-byte message sent; busy falls after the 2nd WAIT; no second ack.
- Reset mid-message: reset asserted 5 clocks after the first tx_start → tx_start=0 and ack=0 within 1 clock. The second byte never appears; the next tx_start is at least 12 clocks after reset deassertion.
- Parameter variant: GAP_CYCLES=3, MSG_BYTES=3 → three tx_starts spaced 14 clocks apart; ack only on the first.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the FSM encoding, the idle-line byte and the delay-counter sizing helper.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } tx_state_e;

  localparam int FRAME_CYCLES_MIN = 11;
  localparam logic [7:0] IDLE_LINE_BYTE = 8'hFF;

  // Bits needed to hold values 0..max_value.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: the winner is the first asserted request
// found searching upward from ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Scan from the farthest rotation back to ptr+1 so the nearest hit is the last write.
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          winner = PW'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one bit-rate 8N1 serializer between NREQ requesters, sending each granted
// fixed-length message as back-to-back frames paced by counting bit periods.
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MSG_BYTES    = 2,
  parameter int FRAME_CYCLES = 11,
  parameter int GAP_CYCLES   = 1,
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk_115200hz,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*MSG_BYTES*8-1:0] req_msg,
  output logic [NREQ-1:0]             ack,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  output tx_state_e                   state_dbg
);

  localparam int SLOT = FRAME_CYCLES + GAP_CYCLES;
  localparam int CW   = cnt_width(SLOT - 1);
  localparam int BW   = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SLOT - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(MSG_BYTES - 1);
  localparam logic [GW-1:0] PTR_RESET  = GW'(NREQ - 1);

  // Handshake: req[i] is a level held by requester i until it sees a one-cycle
  // ack[i]; the message is captured on the IDLE edge that grants it, so req and
  // req_msg may change freely from the ack cycle onward.

  tx_state_e      state, state_nx;
  logic [GW-1:0]  ptr, win;
  logic           win_valid;
  logic [BW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           cnt_done;
  logic [7:0]     msg_q     [MSG_BYTES];
  logic [7:0]     req_bytes [NREQ][MSG_BYTES];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    for (genvar gj = 0; gj < MSG_BYTES; gj++) begin : g_byte
      assign req_bytes[gi][gj] = req_msg[(gi*MSG_BYTES + gj)*8 +: 8];
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  // The decrement to zero and the state change share one edge, so a slot is
  // SEND plus SLOT-1 WAIT cycles and tx_start pulses land exactly SLOT apart.
  assign cnt_done = (cnt == CW'(1));

  always_ff @(posedge clk_115200hz) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_HOLD: if (cnt_done) state_nx = ST_IDLE;
      ST_IDLE: if (win_valid) state_nx = ST_SEND;
      ST_SEND: state_nx = ST_WAIT;
      ST_WAIT: if (cnt_done) state_nx = (idx == LAST_BYTE) ? ST_IDLE : ST_SEND;
      default: state_nx = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      ptr <= PTR_RESET;
      idx <= '0;
      cnt <= CNT_RELOAD;
      for (int j = 0; j < MSG_BYTES; j++) msg_q[j] <= IDLE_LINE_BYTE;
    end else begin
      case (state)
        ST_HOLD: cnt <= cnt - CW'(1);
        ST_IDLE: begin
          if (win_valid) begin
            ptr <= win;
            idx <= '0;
            for (int j = 0; j < MSG_BYTES; j++) msg_q[j] <= req_bytes[win][j];
          end
        end
        ST_SEND: cnt <= CNT_RELOAD;
        ST_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt_done && (idx != LAST_BYTE)) idx <= idx + BW'(1);
        end
        default: ;
      endcase
    end
  end

  // tx_data follows the latched byte, so it holds from SEND through WAIT and IDLE.
  always_comb begin
    tx_start = 1'b0;
    ack      = '0;
    busy     = (state != ST_IDLE);
    tx_data  = msg_q[idx];
    if (state == ST_SEND) begin
      tx_start = 1'b1;
      if (idx == '0) ack[ptr] = 1'b1;
    end
  end

  assign grant_id  = ptr;
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic checked each
// cycle against a time-slot reference model and a serializer/line-decoder model.
module tb_uart_tx_scheduler;
  import uart_tx_pkg::*;

  localparam int NREQ  = 4;
  localparam int MB    = 2;
  localparam int FRAME = 11;
  localparam int GAP   = 1;
  localparam int P     = FRAME + GAP;
  localparam int MB3   = 3;
  localparam int GAP3  = 3;
  localparam int P3    = FRAME + GAP3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*MB*8-1:0] req_msg;
  logic [NREQ-1:0]      ack;
  logic [1:0]           grant_id;
  logic                 busy, tx_start;
  logic [7:0]           tx_data;
  tx_state_e            state_dbg;

  logic                  reset3;
  logic [NREQ-1:0]       req3;
  logic [NREQ*MB3*8-1:0] req_msg3;
  logic [NREQ-1:0]       ack3;
  logic [1:0]            grant_id3;
  logic                  busy3, tx_start3;
  logic [7:0]            tx_data3;
  tx_state_e             state_dbg3;

  uart_tx_scheduler #(.NREQ(NREQ), .MSG_BYTES(MB), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) u_dut (
    .clk_115200hz (clk), .reset (reset), .req (req), .req_msg (req_msg), .ack (ack),
    .grant_id (grant_id), .busy (busy), .tx_start (tx_start), .tx_data (tx_data),
    .state_dbg (state_dbg)
  );

  uart_tx_scheduler #(.NREQ(NREQ), .MSG_BYTES(MB3), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP3)) u_dut3 (
    .clk_115200hz (clk), .reset (reset3), .req (req3), .req_msg (req_msg3), .ack (ack3),
    .grant_id (grant_id3), .busy (busy3), .tx_start (tx_start3), .tx_data (tx_data3),
    .state_dbg (state_dbg3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Requester stimulus state
  logic [NREQ-1:0] want, pulse;
  logic [7:0]      msg_b [NREQ][MB];
  bit              sticky;

  // Reference model: each grant books MB frame slots of P clocks, then one IDLE clock.
  typedef struct {
    int              at;
    logic [7:0]      data;
    logic [NREQ-1:0] ackm;
  } send_t;
  send_t      sched_q[$];
  logic [7:0] exp_q[$];
  int         free_at;
  int         m_ptr, m_grant;
  logic [7:0] m_data;

  // Serializer / line decoder model
  bit         ser_act, rx_ok;
  int         ser_start;
  logic [7:0] rx_byte;
  logic [7:0] rx_log[$];
  int         ack_log[$];
  int         first_start;

  task automatic step(input bit rst_v);
    logic            exp_start;
    logic [NREQ-1:0] exp_ack, oh;
    int              pos, w;
    bit              found;
    @(negedge clk);
    exp_start = 1'b0;
    exp_ack   = '0;
    if (sched_q.size() > 0 && sched_q[0].at == cyc) begin
      exp_start = 1'b1;
      exp_ack   = sched_q[0].ackm;
      m_data    = sched_q[0].data;
      exp_q.push_back(sched_q[0].data);
      void'(sched_q.pop_front());
    end
    check("tx_start", tx_start, exp_start);
    check("ack", ack, exp_ack);
    check("busy", busy, cyc < free_at);
    check("grant_id", grant_id, m_grant);
    check("tx_data", tx_data, m_data);

    // Line: pos 0 start bit, pos 1..8 data LSB first, pos 9 stop bit.
    pos = cyc - ser_start;
    if (ser_act && pos >= 1 && pos <= 8) rx_byte[pos-1] = tx_data[pos-1];
    if (ser_act && pos == 9 && rx_ok) begin
      rx_log.push_back(rx_byte);
      if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
      else                  check("rx_unexpected", rx_byte, 32'hFFFF_FFFF);
    end
    if (ser_act && pos >= FRAME) ser_act = 1'b0;
    if (tx_start === 1'b1) begin
      check("ser_idle_at_start", ser_act, 1'b0);
      ser_act   = 1'b1;
      ser_start = cyc;
      rx_ok     = 1'b1;
      if (first_start < 0) first_start = cyc;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1) begin
        ack_log.push_back(i);
        if (!sticky) want[i] = 1'b0;
      end
    end

    // Drive inputs for the edge that ends this cycle.
    reset = rst_v;
    req   = want | pulse;
    for (int i = 0; i < NREQ; i++)
      for (int b = 0; b < MB; b++) req_msg[(i*MB + b)*8 +: 8] = msg_b[i][b];

    if (rst_v) begin
      sched_q.delete();
      exp_q.delete();
      rx_ok   = 1'b0;
      m_ptr   = NREQ - 1;
      m_grant = NREQ - 1;
      m_data  = 8'hFF;
      free_at = cyc + P;
    end else if (cyc >= free_at && req != '0) begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(m_ptr + k) % NREQ]) begin
          found = 1'b1;
          w     = (m_ptr + k) % NREQ;
        end
      end
      m_ptr   = w;
      m_grant = w;
      oh      = '0;
      oh[w]   = 1'b1;
      for (int b = 0; b < MB; b++)
        sched_q.push_back('{at: cyc + 1 + b*P, data: msg_b[w][b], ackm: (b == 0) ? oh : '0});
      free_at = cyc + 1 + MB*P;
    end
    pulse = '0;
    cyc++;
  endtask

  // ---------------- main sequence ----------------
  int exp_order[4] = '{0, 1, 3, 0};
  int rel, got_i;
  int         starts3[$];
  logic [7:0] data3[$];
  int         acks3;

  initial begin
    reset = 1'b1; req = '0; req_msg = '0;
    reset3 = 1'b1; req3 = '0; req_msg3 = '0;
    want = '0; pulse = '0; sticky = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int b = 0; b < MB; b++) msg_b[i][b] = 8'($urandom);
    sched_q.delete(); exp_q.delete();
    m_ptr = NREQ - 1; m_grant = NREQ - 1; m_data = 8'hFF; free_at = P;
    ser_act = 1'b0; rx_ok = 1'b0; ser_start = -100; first_start = -1;
    repeat (3) @(posedge clk);

    // Post-reset holdoff with req[0] already waiting
    step(1'b1);
    check("state_dbg_reset", state_dbg, ST_HOLD);
    step(1'b1);
    want[0] = 1'b1;
    rel = cyc; first_start = -1;
    repeat (40) step(1'b0);
    check("holdoff_first_start", first_start, rel + P);

    // Simultaneous constant requests: round-robin order
    sticky = 1'b1; want = 4'b1011;
    step(1'b1); step(1'b1);
    ack_log.delete();
    repeat (100) step(1'b0);
    for (int k = 0; k < 4; k++) begin
      got_i = (k < ack_log.size()) ? ack_log[k] : -1;
      check("rr_order", got_i, exp_order[k]);
    end

    // Data integrity through the line decoder
    sticky = 1'b0; want = '0;
    step(1'b1); step(1'b1);
    rx_log.delete();
    msg_b[2][0] = 8'h3C; msg_b[2][1] = 8'hA5; want[2] = 1'b1;
    repeat (45) step(1'b0);
    check("rx_count", rx_log.size(), 2);
    check("rx_first", (rx_log.size() > 0) ? rx_log[0] : 8'h00, 8'h3C);
    check("rx_second", (rx_log.size() > 1) ? rx_log[1] : 8'h00, 8'hA5);

    // One-cycle request pulse is still sent in full, acked once
    for (int n = 0; n < 100 && cyc < free_at; n++) step(1'b0);
    msg_b[1][0] = 8'($urandom); msg_b[1][1] = 8'($urandom);
    pulse[1] = 1'b1;
    ack_log.delete();
    repeat (2*P + 10) step(1'b0);
    check("drop_ack_count", ack_log.size(), 1);
    check("drop_ack_id", (ack_log.size() > 0) ? ack_log[0] : -1, 1);

    // Reset five clocks after the first tx_start of a message
    msg_b[3][0] = 8'($urandom); msg_b[3][1] = 8'($urandom);
    want[3] = 1'b1; first_start = -1;
    for (int n = 0; n < 40 && first_start < 0; n++) step(1'b0);
    check("midreset_start_seen", first_start >= 0, 1'b1);
    for (int n = 0; n < 10 && cyc < first_start + 5; n++) step(1'b0);
    step(1'b1);
    first_start = -1;
    repeat (30) step(1'b0);
    check("midreset_no_restart", first_start, -1);

    // Random traffic with occasional resets and held-after-ack requesters
    for (int n = 0; n < 800; n++) begin
      sticky = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!want[i] && $urandom_range(0, 7) == 0) begin
          want[i] = 1'b1;
          for (int b = 0; b < MB; b++) msg_b[i][b] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) pulse[$urandom_range(0, NREQ-1)] = 1'b1;
      step($urandom_range(0, 199) == 0);
    end

    // Variant: GAP_CYCLES=3, MSG_BYTES=3
    acks3 = 0;
    for (int n = 0; n < 3*P3 + 25; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("v_reset_tx_data", tx_data3, 8'hFF);
        check("v_reset_grant", grant_id3, 2'd3);
        check("v_reset_busy", busy3, 1'b1);
      end
      if (tx_start3 === 1'b1) begin
        starts3.push_back(n);
        data3.push_back(tx_data3);
      end
      if (ack3 != '0) begin
        acks3++;
        check("v_ack_id", ack3, 4'b0100);
        req3 = '0;
      end
      reset3 = 1'b0;
      if (n == 0) begin
        req3 = 4'b0100;
        req_msg3[48 +: 24] = 24'h112233;
      end
    end
    while (starts3.size() < 3) starts3.push_back(-1000);
    while (data3.size() < 3) data3.push_back(8'h00);
    check("v_first_start", starts3[0], P3);
    check("v_spacing_1", starts3[1] - starts3[0], P3);
    check("v_spacing_2", starts3[2] - starts3[1], P3);
    check("v_start_count", starts3.size(), 3);
    check("v_byte0", data3[0], 8'h33);
    check("v_byte1", data3[1], 8'h22);
    check("v_byte2", data3[2], 8'h11);
    check("v_ack_count", acks3, 1);
    check("v_busy_end", busy3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
